// File: rtl/crc_rx_pkg.sv
// Shared definitions for the CRC-16 receive path: default polynomial/seed
// and the 3-bit receiver state encodings.
package crc_rx_pkg;

  localparam logic [15:0] CRC_POLY_DEFAULT = 16'h1021;
  localparam logic [15:0] CRC_INIT_DEFAULT = 16'hFFFF;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_PAYLOAD = 3'd1;
  localparam state_t ST_CRC1    = 3'd2;
  localparam state_t ST_CRC2    = 3'd3;
  localparam state_t ST_REPORT  = 3'd4;

endpackage

// File: rtl/crc16_byte.sv
// One-byte CRC-16 update, MSB-first and non-reflected.
// This block is shared with the transmit side, so it stays purely combinational.
module crc16_byte
  import crc_rx_pkg::*;
#(
  parameter logic [15:0] POLY = CRC_POLY_DEFAULT
) (
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] acc;

  always_comb begin
    acc = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      acc = acc[15] ? ({acc[14:0], 1'b0} ^ POLY) : {acc[14:0], 1'b0};
    end
    crc_out = acc;
  end

endmodule

// File: rtl/crc_rx.sv
// Frame receiver: length byte, N payload bytes, then a big-endian CRC-16.
// Payload is forwarded one cycle late; each frame ends with a one-cycle report.
module crc_rx
  import crc_rx_pkg::*;
#(
  parameter logic [15:0] POLY = CRC_POLY_DEFAULT,
  parameter logic [15:0] INIT = CRC_INIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       frame_done,
  output logic       crc_ok,
  output logic [7:0] err_count
);

  state_t      state;
  logic [7:0]  count;
  logic [15:0] crc;
  logic [15:0] crc_next;
  logic [7:0]  crc_hi;
  logic        xfer;
  logic        match;

  crc16_byte #(.POLY(POLY)) u_crc16_byte (
    .crc_in  (crc),
    .data    (rx_data),
    .crc_out (crc_next)
  );

  // Undefined encodings deassert rx_ready as well, so nothing is accepted there.
  assign rx_ready   = (state == ST_IDLE) || (state == ST_PAYLOAD) ||
                      (state == ST_CRC1) || (state == ST_CRC2);
  assign frame_done = (state == ST_REPORT);
  assign xfer       = rx_valid && rx_ready;
  assign match      = ({crc_hi, rx_data} == crc);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      count     <= 8'd0;
      crc       <= INIT;
      crc_hi    <= 8'd0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      crc_ok    <= 1'b0;
      err_count <= 8'd0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: if (xfer) begin
          count <= rx_data;
          crc   <= INIT;
          state <= (rx_data == 8'd0) ? ST_CRC1 : ST_PAYLOAD;
        end
        ST_PAYLOAD: if (xfer) begin
          crc       <= crc_next;
          count     <= count - 8'd1;
          out_valid <= 1'b1;
          out_data  <= rx_data;
          if (count == 8'd1) state <= ST_CRC1;
        end
        ST_CRC1: if (xfer) begin
          crc_hi <= rx_data;
          state  <= ST_CRC2;
        end
        // The verdict lands here so it is already visible in the report cycle.
        ST_CRC2: if (xfer) begin
          crc_ok <= match;
          if (!match && err_count != 8'hFF) err_count <= err_count + 8'd1;
          state  <= ST_REPORT;
        end
        ST_REPORT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_rx.sv
// Self-checking bench for crc_rx: table-driven known frames, random frames
// against a bitwise CRC model, mid-frame reset and error-counter saturation.
module tb_crc_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       frame_done;
  logic       crc_ok;
  logic [7:0] err_count;

  int errors = 0;
  int checks = 0;
  int exp_err = 0;

  logic [7:0] seen_q[$];
  int         done_cnt;
  int         ready_low;

  typedef struct {
    string       name;
    string       payload;
    logic [15:0] crc_sent;
    bit          gappy;
    bit          exp_ok;
  } vec_t;

  vec_t tbl[4];

  crc_rx dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .frame_done (frame_done),
    .crc_ok     (crc_ok),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  // Observe outputs on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (out_valid) seen_q.push_back(out_data);
    if (frame_done) done_cnt++;
    if (reset && !rx_ready) ready_low++;
  end

  // Reference CRC treats the payload as one long bit stream divided by the polynomial.
  function automatic logic [15:0] model_crc(input logic [7:0] msg[$]);
    logic [15:0] r;
    logic        fb;
    r = 16'hFFFF;
    foreach (msg[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = r[15] ^ msg[i][b];
        r  = {r[14:0], 1'b0};
        if (fb) r = r ^ 16'h1021;
      end
    end
    return r;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic drive_bytes(input logic [7:0] bytes[$], input bit gappy, output bit timed_out);
    int idx;
    int cyc;
    bit xf;
    idx = 0;
    cyc = 0;
    while (idx < bytes.size() && cyc < 4000) begin
      rx_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      rx_data  = rx_valid ? bytes[idx] : 8'($urandom);
      @(negedge clk);
      xf = rx_valid && rx_ready;
      @(posedge clk);
      #1;
      if (xf) idx++;
      cyc++;
    end
    rx_valid  = 1'b0;
    rx_data   = 8'($urandom);
    timed_out = (idx < bytes.size());
  endtask

  task automatic apply_stimulus(input string name, input logic [7:0] payload[$],
                                input logic [15:0] crc_sent, input bit gappy, input bit exp_ok);
    logic [7:0] bytes[$];
    bit         to;
    int         same;
    seen_q.delete();
    done_cnt  = 0;
    ready_low = 0;
    bytes.push_back(8'(payload.size()));
    foreach (payload[i]) bytes.push_back(payload[i]);
    bytes.push_back(crc_sent[15:8]);
    bytes.push_back(crc_sent[7:0]);
    drive_bytes(bytes, gappy, to);
    repeat (3) @(posedge clk);
    #1;
    if (!exp_ok && exp_err < 255) exp_err++;
    check_output({name, ".timeout"}, int'(to), 0);
    check_output({name, ".out_count"}, seen_q.size(), payload.size());
    same = (seen_q.size() == payload.size());
    if (same) foreach (payload[i]) if (seen_q[i] != payload[i]) same = 0;
    check_output({name, ".out_data"}, same, 1);
    check_output({name, ".frame_done"}, done_cnt, 1);
    check_output({name, ".crc_ok"}, int'(crc_ok), int'(exp_ok));
    check_output({name, ".err_count"}, int'(err_count), exp_err);
    check_output({name, ".ready_low"}, ready_low, 1);
  endtask

  initial begin
    logic [7:0]  pl[$];
    logic [7:0]  part[$];
    logic [15:0] c;
    bit          ok;
    bit          to;
    int          n;

    tbl[0] = '{"good",      "123456789", 16'h29B1, 1'b0, 1'b1};
    tbl[1] = '{"bad_low",   "123456789", 16'h29B0, 1'b0, 1'b0};
    tbl[2] = '{"empty",     "",          16'hFFFF, 1'b0, 1'b1};
    tbl[3] = '{"good_gaps", "123456789", 16'h29B1, 1'b1, 1'b1};

    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset.out_valid", int'(out_valid), 0);
    check_output("reset.frame_done", int'(frame_done), 0);
    check_output("reset.crc_ok", int'(crc_ok), 0);
    check_output("reset.err_count", int'(err_count), 0);
    check_output("reset.out_data", int'(out_data), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_output("reset.rx_ready", int'(rx_ready), 1);
    @(posedge clk);
    #1;

    for (int t = 0; t < 4; t++) begin
      pl.delete();
      for (int i = 0; i < tbl[t].payload.len(); i++) pl.push_back(tbl[t].payload[i]);
      apply_stimulus(tbl[t].name, pl, tbl[t].crc_sent, tbl[t].gappy, tbl[t].exp_ok);
    end

    for (int r = 0; r < 8; r++) begin
      pl.delete();
      n = $urandom_range(0, 24);
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      c  = model_crc(pl);
      ok = 1'($urandom_range(0, 1));
      if (!ok) c = c ^ (16'h1 << $urandom_range(0, 15));
      apply_stimulus($sformatf("rand%0d", r), pl, c, 1'($urandom_range(0, 1)), ok);
    end

    // Abandon a frame after the length byte and five payload bytes.
    seen_q.delete();
    done_cnt = 0;
    part.delete();
    part.push_back(8'd9);
    for (int i = 0; i < 5; i++) part.push_back(8'h31 + 8'(i));
    drive_bytes(part, 1'b0, to);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_err = 0;
    @(negedge clk);
    check_output("midreset.frame_done", done_cnt, 0);
    check_output("midreset.err_count", int'(err_count), 0);
    check_output("midreset.rx_ready", int'(rx_ready), 1);
    @(posedge clk);
    #1;
    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
    apply_stimulus("after_reset", pl, 16'h29B1, 1'b0, 1'b1);

    pl.delete();
    for (int f = 0; f < 256; f++) apply_stimulus($sformatf("sat%0d", f), pl, 16'h0000, 1'b0, 1'b0);
    check_output("sat.final", int'(err_count), 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crc_rx.md
CRC_RX -- requirements
Module: crc_rx

Interface
REQ-001 Parameter POLY, default 16'h1021, CRC-16 generator polynomial.
REQ-002 Parameter INIT, default 16'hFFFF, CRC register value at the start of each frame.
REQ-003 Port clk, input, 1, single clock; all logic on posedge clk.
REQ-004 Port reset, input, 1, reset, synchronous and active-low.
REQ-005 Port rx_valid, input, 1, upstream byte valid.
REQ-006 Port rx_data, input, 8, upstream byte.
REQ-007 Port rx_ready, output, 1, receiver can accept a byte.
REQ-008 Port out_valid, output, 1, payload byte strobe.
REQ-009 Port out_data, output, 8, forwarded payload byte.
REQ-010 Port frame_done, output, 1, single-cycle end-of-frame pulse.
REQ-011 Port crc_ok, output, 1, received CRC matches computed CRC; qualified by frame_done.
REQ-012 Port err_count, output, 8, saturating count of frames with CRC mismatch.

Function
REQ-013 A byte SHALL transfer only on a cycle with rx_valid=1 and rx_ready=1; rx_data on any other cycle SHALL be ignored.
REQ-014 Frame format SHALL be: length byte N (0..255), then N payload bytes, then CRC high byte (CRC1), then CRC low byte (CRC2).
REQ-015 FSM states SHALL be IDLE, PAYLOAD, CRC1, CRC2, REPORT.
REQ-016 IDLE: on transfer, load remaining count with N and the CRC register with INIT; go to PAYLOAD if N>0, else go to CRC1.
REQ-017 PAYLOAD: on each transfer, update the CRC with the byte and decrement the count; on the transfer at count=1, go to CRC1.
REQ-018 CRC1: on transfer, latch the byte as the received high byte; go to CRC2.
REQ-019 CRC2: on transfer, compare {high, byte} with the CRC register; go to REPORT.
REQ-020 REPORT: frame_done=1 and crc_ok=compare result for exactly one cycle; rx_ready=0; next state IDLE unconditionally.
REQ-021 rx_ready SHALL be 1 in IDLE, PAYLOAD, CRC1 and CRC2, and 0 only in REPORT.
REQ-022 The CRC SHALL be MSB-first, non-reflected, with no final XOR, computed over payload bytes only (not the length or CRC bytes).
REQ-023 out_valid/out_data SHALL be registered: asserted the cycle after each PAYLOAD transfer, for one cycle, with the accepted byte.
REQ-024 If the compare fails, err_count SHALL increment in the REPORT cycle and saturate at 255.
REQ-025 crc_ok SHALL hold its last value outside REPORT; frame_done SHALL be 0 outside REPORT.
REQ-026 For N=0, the expected CRC SHALL equal INIT (0xFFFF with default INIT).
REQ-027 Undefined state encodings SHALL return to IDLE on the next cycle with no outputs asserted.

Reset
REQ-028 While reset=0 at posedge clk: state=IDLE, CRC register=INIT, count=0, out_valid=0, out_data=0, frame_done=0, crc_ok=0, err_count=0; rx_ready SHALL be 1 from the first cycle after reset releases.
REQ-029 Reset mid-frame SHALL abandon the frame with no frame_done pulse and no err_count change.

Structure
REQ-030 A shared package SHALL hold the state enum (3-bit encodings) and the default POLY/INIT constants.
REQ-031 The one-byte CRC update SHALL be a combinational sub-module crc16_byte (inputs crc_in[15:0], data[7:0]; output crc_out[15:0]), shared with the transmit side.

Verification
REQ-032 Frame 09,"123456789",29,B1 streamed with rx_valid=1 continuously -> nine out_valid pulses carrying 31..39, then frame_done=1, crc_ok=1, err_count=0.
REQ-033 Same frame with last byte B0 -> frame_done=1, crc_ok=0, err_count=1.
REQ-034 Frame 00,FF,FF -> no out_valid, frame_done=1, crc_ok=1.
REQ-035 Good frame with rx_valid toggled randomly -> identical outputs to REQ-032; rx_ready=0 exactly one cycle per frame.
REQ-036 reset=0 asserted after byte 5 of the REQ-032 frame, then the full frame resent -> no frame_done before reset, then one correct frame_done with crc_ok=1.
REQ-037 256 consecutive bad frames -> err_count stops at 255.
